// File: rtl/swap_reg_file_if.sv
// Host-side bundle for swap_reg_file: write port, read port, swap control and status.
interface swap_reg_file_if #(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DATA_W = 8
);
  logic              we;
  logic [ADDR_W-1:0] address_w;
  logic [DATA_W-1:0] data_w;
  logic [ADDR_W-1:0] address_r;
  logic [DATA_W-1:0] data_r;
  logic              swap_req;
  logic [ADDR_W-1:0] swap_a;
  logic [ADDR_W-1:0] swap_b;
  logic              swap_busy;
  logic              swap_done;
  logic              wr_drop;

  modport master (
    output we, address_w, data_w, address_r, swap_req, swap_a, swap_b,
    input  data_r, swap_busy, swap_done, wr_drop
  );

  modport slave (
    input  we, address_w, data_w, address_r, swap_req, swap_a, swap_b,
    output data_r, swap_busy, swap_done, wr_drop
  );
endinterface

// File: rtl/swap_reg_file.sv
// Register file with one write port, combinational read port and an in-place
// swap engine that time-shares the single write port over a 4-state FSM.
module swap_reg_file #(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DATA_W = 8
) (
  input logic              clk,
  input logic              rst_n,
  swap_reg_file_if.slave   bus
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {IDLE, READ, WR_A, WR_B} state_e;

  state_e            state_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] addr_a_q, addr_b_q;
  logic [DATA_W-1:0] tmp_a_q, tmp_b_q;
  logic              done_q, drop_q;

  // Next write to the physical port: host owns it in IDLE, the swap otherwise.
  logic              wr_en_d;
  logic [ADDR_W-1:0] wr_addr_d;
  logic [DATA_W-1:0] wr_data_d;

  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = bus.address_w;
    wr_data_d = bus.data_w;
    unique case (state_q)
      IDLE: wr_en_d = bus.we;
      WR_A: begin
        wr_en_d   = 1'b1;
        wr_addr_d = addr_a_q;
        wr_data_d = tmp_b_q;
      end
      WR_B: begin
        wr_en_d   = 1'b1;
        wr_addr_d = addr_b_q;
        wr_data_d = tmp_a_q;
      end
      default: wr_en_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en_d) begin
      mem_q[wr_addr_d] <= wr_data_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_a_q <= '0;
      addr_b_q <= '0;
      tmp_a_q  <= '0;
      tmp_b_q  <= '0;
      done_q   <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      drop_q <= bus.we && (state_q != IDLE);
      unique case (state_q)
        IDLE: begin
          if (bus.swap_req) begin
            addr_a_q <= bus.swap_a;
            addr_b_q <= bus.swap_b;
            state_q  <= READ;
          end
        end
        // Capture one edge after acceptance so a same-edge host write is seen.
        READ: begin
          tmp_a_q <= mem_q[addr_a_q];
          tmp_b_q <= mem_q[addr_b_q];
          state_q <= WR_A;
        end
        WR_A: state_q <= WR_B;
        WR_B: begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.data_r    = mem_q[bus.address_r];
  assign bus.swap_busy = (state_q != IDLE);
  assign bus.swap_done = done_q;
  assign bus.wr_drop   = drop_q;
endmodule
